// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame width and baud divider derivation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_operand_if.sv
// Byte delivery bus from the UART receiver to the register file's UART input port.
interface uart_rx_operand_if;

  logic       uart_signal;
  logic       uart_flag;
  logic [7:0] uart_rx_data;
  logic       frame_error;
  logic       busy;

  modport master (
    output uart_signal,
    output uart_flag,
    output uart_rx_data,
    output frame_error,
    output busy
  );

  modport slave (
    input uart_signal,
    input uart_flag,
    input uart_rx_data,
    input frame_error,
    input busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, re-phased by restart.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_operand.sv
// 8N1 UART receiver feeding the operand registers; each byte is tagged with an
// alternating pair flag so consecutive bytes land in operand 1 then operand 2.
module uart_rx_operand
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              pair_clear,
  uart_rx_operand_if.master bus
);

  localparam int DIV      = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TCW      = $clog2(OVERSAMPLE);
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int ICW      = $clog2(TO_LIMIT + 1);

  localparam logic [TCW-1:0] HALF_LAST    = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] BIT_LAST     = TCW'(OVERSAMPLE - 1);
  localparam logic [ICW-1:0] IDLE_LAST    = ICW'(TO_LIMIT - 1);
  localparam logic [2:0]     BIT_IDX_LAST = 3'(DATA_BITS - 1);

  state_t               state;
  logic [TCW-1:0]       tick_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 pair_ptr;
  logic [ICW-1:0]       idle_cnt;

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic fall;
  logic tick;
  logic start_edge;
  logic stop_sample;
  logic commit_now;
  logic ferr_now;
  logic timeout_hit;

  // rx_prev sits behind the synchroniser so edge detection only sees settled values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall       = rx_prev & ~rx_sync;
  assign start_edge = (state == ST_IDLE) && fall;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(start_edge),
    .tick   (tick)
  );

  assign stop_sample = (state == ST_STOP) && tick && (tick_cnt == BIT_LAST);
  assign commit_now  = stop_sample && rx_sync;
  assign ferr_now    = stop_sample && !rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TCW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
              if (bit_idx == BIT_IDX_LAST) begin
                bit_idx <= '0;
                state   <= ST_STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TCW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= rx_sync ? ST_IDLE : ST_BREAK;
            end else begin
              tick_cnt <= tick_cnt + TCW'(1);
            end
          end
        end
        ST_BREAK: begin
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.uart_signal  <= 1'b0;
      bus.uart_flag    <= 1'b0;
      bus.uart_rx_data <= 8'h00;
      bus.frame_error  <= 1'b0;
    end else begin
      bus.uart_signal <= commit_now;
      bus.frame_error <= ferr_now;
      if (commit_now) begin
        bus.uart_rx_data <= shift_reg;
        bus.uart_flag    <= pair_ptr;
      end
    end
  end

  // An explicit clear outranks the commit toggle; the commit itself still uses the old pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_ptr <= 1'b0;
    end else if (pair_clear) begin
      pair_ptr <= 1'b0;
    end else if (commit_now) begin
      pair_ptr <= ~pair_ptr;
    end else if (timeout_hit) begin
      pair_ptr <= 1'b0;
    end
  end

  assign timeout_hit = pair_ptr && (state == ST_IDLE) && !fall && tick && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (fall || commit_now || !pair_ptr || (state != ST_IDLE)) begin
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= timeout_hit ? '0 : idle_cnt + ICW'(1);
    end
  end

  assign bus.busy = (state != ST_IDLE);

endmodule

// File: doc/uart_rx_operand.md
Name: uart_rx_operand

Overview:
- Serial UART receiver that produces the byte stream consumed by the register file's UART input port.
- Deserialises 8N1 frames from the board RX pin using an oversampled baud tick.
- Delivers each byte with a one-cycle `uart_signal` strobe.
- Tags each byte with `uart_flag`, which alternates 0/1 so consecutive bytes land in operand register 1 and then operand register 2.
- Sits at the top level, between the RX pad and the CPU's UART inputs.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 9600, serial bit rate
- OVERSAMPLE, 16, baud ticks per bit; must be even and ≥ 8
- TIMEOUT_BITS, 40, bit times of line idle after an operand-1 byte before the pair pointer returns to 0

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- rx  in  1  asynchronous serial line; idle high
- pair_clear  in  1  synchronous force of the pair pointer to 0
- uart_signal  out  1  one-cycle pulse: new byte valid on `uart_rx_data`/`uart_flag`
- uart_flag  out  1  0: byte targets operand register 1; 1: byte targets operand register 2
- uart_rx_data  out  8  received byte; held until the next commit
- frame_error  out  1  one-cycle pulse when the stop bit samples 0
- busy  out  1  high while not in IDLE

Behaviour:
- One clock; reset is synchronous and active-high. No asynchronous reset anywhere.
- Reset values:
  - outputs: `uart_signal`=0, `uart_flag`=0, `uart_rx_data`=8'h00, `frame_error`=0, `busy`=0
  - internal: synchroniser FFs=1, pair pointer=0, state=IDLE, all counters=0
- Reset mid-frame discards the partial byte. No strobe is emitted.
- rx passes through a 2-FF synchroniser. The edge detector compares the synchronised value against its previous value.
- Baud tick:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated; default 651.
  - Tick is a one-cycle pulse every DIV clocks.
  - The tick counter restarts at 0 on entry to START, so the sample phase is aligned to the detected falling edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on a synchronised falling edge → START; tick count=0.
  - START: at tick OVERSAMPLE/2, sample rx.
    - 0 → DATA, bit index=0, tick count=0.
    - 1 → IDLE (glitch rejection, no output).
  - DATA: every OVERSAMPLE ticks, sample rx into shift register LSB-first. After bit index 7 → STOP.
  - STOP: after OVERSAMPLE ticks, sample rx.
    - 1 → commit, then → IDLE.
    - 0 → `frame_error`=1 for one cycle, no commit, → BREAK.
  - BREAK: wait for synchronised rx=1 → IDLE.
- Commit cycle (registered, same clock edge):
  - `uart_rx_data` ← shift register
  - `uart_flag` ← pair pointer
  - `uart_signal` ← 1 for exactly one cycle
  - pair pointer toggles
- Latency: `uart_signal` rises one clock after the stop-bit sample edge.
- Timeout: while pair pointer=1 and state=IDLE, an idle counter counts baud ticks. Reaching TIMEOUT_BITS*OVERSAMPLE sets pair pointer ← 0. The counter clears on any falling edge or commit.
- `pair_clear`:
  - Forces pointer ← 0 next cycle.
  - If asserted in a commit cycle, the commit uses the old pointer, and clear wins over toggle.
  - Does not affect frame reception.
- `frame_error` does not move the pair pointer.
- Back-to-back frames: a falling edge detected in the cycle immediately after the commit is accepted. No dead time beyond the stop-bit sample point.
- `busy`=1 in START/DATA/STOP/BREAK.

Decomposition:
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - localparam DIV derivation function
  - DATA_BITS=8 constant
- One sub-module: `uart_baud_tick` (parameter DIV; ports clk, reset, restart, tick). The transmitter reuses it later.
- The FSM, shift register, pair pointer and timeout live in the top module.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, giving DIV=10 and 160 clocks per bit.
1. Send frame 8'hA5 after reset → exactly one `uart_signal` pulse; `uart_rx_data`=8'hA5, `uart_flag`=0; pulse 1 clk after stop sample (≈1521 clk after the start edge incl. 2-FF sync).
2. Send 8'h3C then 8'hC3 back-to-back → two pulses. First carries `uart_flag`=0 with data 3C; second carries `uart_flag`=1 with data C3. Third byte 8'h01 → `uart_flag`=0.
3. Drive rx low for 40 clk (< half bit) then high → no `uart_signal`, no `frame_error`, `busy` returns to 0 within 2+80 clk.
4. Frame 8'hFF with stop bit held 0 for 2 bit times → one `frame_error` pulse, no `uart_signal`, `busy` stays 1 until rx returns high. The next byte 8'h55 still gets `uart_flag`=0.
5. Send 8'h11, then idle 41 bit times, then 8'h22 → second byte has `uart_flag`=0 (timeout). With 39 bit times idle instead → `uart_flag`=1.
6. Assert reset during data bit 4 of 8'h7E, then send 8'h81 → no pulse for 7E; 8'h81 received with `uart_flag`=0. Also assert `pair_clear` in the commit cycle of an operand-1 byte → that byte carries `uart_flag`=0 and the next byte also carries `uart_flag`=0.
